// File: rtl/perf_monitor.sv
// perf_monitor: performance-counter unit fed by the processor retire strobe
// and fetch PC. Counts cycles, retired instructions and stalls while in RUN.
// All counters saturate at all-ones; a sticky flag records saturation.
// Optional feature macro: PERF_BRANCH_COUNT_EN adds a non-sequential-PC
// ("branches") counter at rd_addr=3; without it rd_addr=3 reads 0.
module perf_monitor #(
   parameter int CNT_W = 16,
   parameter int PC_W  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   input  logic             retire,
   input  logic [PC_W-1:0]  pc,
   input  logic [1:0]       rd_addr,
   output logic [CNT_W-1:0] rd_data,
   output logic             running,
   output logic             sat_flag
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            state_q, state_d;
   logic              running_q, running_d;
   logic [CNT_W-1:0]  cyc_q, cyc_d;
   logic [CNT_W-1:0]  ret_q, ret_d;
   logic [CNT_W-1:0]  stl_q, stl_d;
   logic [CNT_W-1:0]  brn_q;
   logic              sat_q, sat_d;
   logic              prev_valid_q, prev_valid_d;
   logic [PC_W-1:0]   prev_pc_q, prev_pc_d;
   logic [CNT_W-1:0]  rd_data_q, rd_data_d;
   logic [CNT_W-1:0]  cyc_sat;
   logic              count_en;
   logic              enter_run;
   logic              stall_hit;

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic en);
      return (en && (v != CNT_MAX)) ? v + 1'b1 : v;
   endfunction

   // A RUN cycle counts unless stop or clear is asserted in it.
   assign count_en  = (state_q == RUN) && !stop && !clear;
   assign enter_run = (state_q != RUN) && (state_d == RUN);
   assign stall_hit = prev_valid_q && (pc == prev_pc_q);
   assign cyc_sat   = sat_inc(cyc_q, 1'b1);

   // State register; running is registered alongside the state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         running_q <= running_d;
      end
   end

   // Next state: stop beats start in RUN; the cycle counter hitting
   // all-ones also forces HALT so a saturated run stops by itself.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, HALT: if (start && !stop) state_d = RUN;
         RUN: begin
            if (stop)                            state_d = HALT;
            else if (!clear && cyc_sat == CNT_MAX) state_d = HALT;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM output: running tracks the state being entered.
   always_comb begin
      running_d = (state_d == RUN);
   end

   // Counter next-state: clear wins over counting; entering RUN drops
   // prev_valid so the first RUN cycle can never see a stall.
   always_comb begin
      cyc_d        = cyc_q;
      ret_d        = ret_q;
      stl_d        = stl_q;
      sat_d        = sat_q;
      prev_valid_d = prev_valid_q;
      prev_pc_d    = prev_pc_q;
      if (clear) begin
         cyc_d        = '0;
         ret_d        = '0;
         stl_d        = '0;
         sat_d        = 1'b0;
         prev_valid_d = 1'b0;
      end else begin
         if (count_en) begin
            cyc_d        = cyc_sat;
            ret_d        = sat_inc(ret_q, retire);
            stl_d        = sat_inc(stl_q, stall_hit);
            prev_pc_d    = pc;
            prev_valid_d = 1'b1;
         end else if (enter_run) begin
            prev_valid_d = 1'b0;
         end
         sat_d = sat_q || (cyc_d == CNT_MAX) || (ret_d == CNT_MAX) ||
                 (stl_d == CNT_MAX) || (brn_q == CNT_MAX);
      end
   end

   // Counter and tracking registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cyc_q        <= '0;
         ret_q        <= '0;
         stl_q        <= '0;
         sat_q        <= 1'b0;
         prev_valid_q <= 1'b0;
         prev_pc_q    <= '0;
      end else begin
         cyc_q        <= cyc_d;
         ret_q        <= ret_d;
         stl_q        <= stl_d;
         sat_q        <= sat_d;
         prev_valid_q <= prev_valid_d;
         prev_pc_q    <= prev_pc_d;
      end
   end

`ifdef PERF_BRANCH_COUNT_EN
   logic [CNT_W-1:0] brn_d;
   logic [PC_W-1:0]  pc_seq;
   logic             brn_hit;

   // A taken branch is any PC change that is not a +1 step (wraps mod 2^PC_W).
   assign pc_seq  = prev_pc_q + 1'b1;
   assign brn_hit = prev_valid_q && (pc != prev_pc_q) && (pc != pc_seq);

   // Branch counter next-state, same clear/saturate rules as the others.
   always_comb begin
      brn_d = brn_q;
      if (clear)         brn_d = '0;
      else if (count_en) brn_d = sat_inc(brn_q, brn_hit);
   end

   // Branch counter register.
   always_ff @(posedge clk) begin
      if (!reset) brn_q <= '0;
      else        brn_q <= brn_d;
   end
`else
   assign brn_q = '0;
`endif

   // Read mux: registered copy of the selected counter's current value.
   always_comb begin
      case (rd_addr)
         2'd0:    rd_data_d = cyc_q;
         2'd1:    rd_data_d = ret_q;
         2'd2:    rd_data_d = stl_q;
         default: rd_data_d = brn_q;
      endcase
   end

   // Read port register.
   always_ff @(posedge clk) begin
      if (!reset) rd_data_q <= '0;
      else        rd_data_q <= rd_data_d;
   end

   assign rd_data  = rd_data_q;
   assign running  = running_q;
   assign sat_flag = sat_q;

endmodule
